sfp_out_serializer: RTL and testbench
=====================================

// Module: sfp_out_serializer
// PURPOSE
//  Downstream drain for one core's SFP output (out_sfp, col lanes x bw_psum bits).
//  Buffers whole vectors in a small FIFO, then streams them lane by lane over a
//  narrow valid/ready bus toward the chip readout.
//  One instance per core, clocked by that core's clock.
// PARAMETERS
//  col        8   lanes per vector
//  bw_psum    19  bits per lane (2*bw+3)
//  fifo_depth 4   vector entries in input FIFO; power of 2, >=2
// PORTS
//  clk        in   1              core clock
//  reset      in   1              asynchronous, active-high
//  in_valid   in   1              in_data holds a vector
//  in_ready   out  1              FIFO can accept a vector
//  in_data    in   col*bw_psum    SFP vector; lane i = bits [i*bw_psum +: bw_psum]
//  out_valid  out  1              out_data holds a lane
//  out_ready  in   1              consumer takes the lane
//  out_data   out  bw_psum        current lane, raw two's-complement bits
//  out_lane   out  $clog2(col)    index of the current lane
//  out_last   out  1              high with lane col-1
//  row_cnt    out  8              completed vectors, mod 256
//  fifo_empty out  1              FIFO status, registered
//  fifo_full  out  1              FIFO status, registered
// BEHAVIOUR
//  Reset
//   - Async assert clears FIFO pointers, shift register, lane counter and row_cnt.
//   - FSM goes to IDLE.
//   - All outputs are 0 except fifo_empty=1.
//   - in_ready is forced to 0 while reset is high.
//  Input side
//   - Push on (in_valid & in_ready); in_ready = !fifo_full.
//   - A push is refused when the FIFO is full, even if a pop happens in the same cycle.
//   - Read/write pointers are $clog2(fifo_depth)+1 bits and wrap naturally.
//   - full = (ptr MSBs differ, lower bits equal); empty = (pointers equal).
//  FSM states
//   IDLE:
//    - out_valid=0.
//    - If !fifo_empty: load the FIFO head into the shift register, pop, set lane=0, go to SHIFT.
//   SHIFT:
//    - out_valid=1; out_data = lane slice `lane`; out_lane = lane.
//    - out_last = (lane==col-1).
//    - On out_ready with lane<col-1: lane increments.
//    - On out_ready with lane==col-1: row_cnt increments (255 -> 0).
//      - If the FIFO is non-empty: load next head, pop, lane=0, stay in SHIFT (no bubble).
//      - Otherwise: go to IDLE.
//   - While out_valid & !out_ready, out_data, out_lane and out_last hold stable.
//  Latency and capacity
//   - A vector pushed at edge N into an idle, empty block gives out_valid=1 after edge N+1.
//     Data is never bypassed around the FIFO.
//   - Capacity is fifo_depth vectors in the FIFO plus 1 in the shift register.
//  Data handling
//   - No arithmetic on data; bits pass through unchanged (sign preserved).
//  Reset mid-stream
//   - All buffered and partially sent vectors are discarded.
//   - No stale lane appears after reset deasserts.
// TESTING
//  T1 Single vector, lane i = i+1, lane 7 = -5 (19'h7FFFB), out_ready=1:
//     - out_valid rises 2 cycles after accept.
//     - 8 beats with out_lane 0..7; lane 7 beat is 19'h7FFFB with out_last=1.
//     - row_cnt=1, then IDLE.
//  T2 Backpressure, out_ready toggled 1/0 on a random pattern:
//     - Lanes are emitted in order 0..7, none dropped or repeated.
//     - out_data holds stable during every stall.
//  T3 Capacity, out_ready=0, in_valid held high:
//     - Exactly 5 vectors are accepted (fifo_full=1), then in_ready=0.
//     - After release, 40 beats come out in push order.
//  T4 Back-to-back, 3 vectors pre-queued, out_ready=1:
//     - 24 consecutive beats with out_valid=1, no gap cycles.
//     - out_last on beats 8, 16 and 24; row_cnt=3.
//  T5 Reset asserted at lane 3 of vector 1 with 2 vectors still queued:
//     - Outputs go to 0 immediately (asynchronous); row_cnt=0; fifo_empty=1.
//     - After deassert, out_valid stays 0 until a new push.
//  T6 256 vectors streamed:
//     - row_cnt wraps to 0.
//     - The FIFO pointers wrap with no loss and no duplication.

Source files
------------

// File: rtl/sfp_out_serializer.sv
// ---------------------------------------------------------------------------
// sfp_out_serializer
//
// Downstream drain for one core's SFP output. Whole vectors of `col` lanes
// (each `bw_psum` bits) are buffered in a small FIFO. They are then streamed
// one lane at a time over a narrow valid/ready bus toward the chip readout.
// There is one instance per core, clocked by that core's clock.
//
// Ports
//   clk         core clock
//   reset       asynchronous, active-high; discards everything in flight
//   in_valid    in_data holds a vector
//   in_ready    FIFO can accept a vector (held low while reset is high)
//   in_data     vector; lane i = bits [i*bw_psum +: bw_psum]
//   out_valid   out_data holds a lane
//   out_ready   consumer takes the lane
//   out_data    current lane, raw two's-complement bits
//   out_lane    index of the current lane
//   out_last    high with lane col-1
//   row_cnt     completed vectors, mod 256
//   fifo_empty  registered FIFO status
//   fifo_full   registered FIFO status
// ---------------------------------------------------------------------------
module sfp_out_serializer #(
  parameter int col        = 8,
  parameter int bw_psum    = 19,
  parameter int fifo_depth = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [col*bw_psum-1:0]   in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [bw_psum-1:0]       out_data,
  output logic [$clog2(col)-1:0]   out_lane,
  output logic                     out_last,
  output logic [7:0]               row_cnt,
  output logic                     fifo_empty,
  output logic                     fifo_full
);

  localparam int AW = $clog2(fifo_depth);
  localparam int PW = AW + 1;
  localparam int LW = $clog2(col);
  localparam int VW = col * bw_psum;
  localparam logic [LW-1:0] LAST_LANE = LW'(col - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [VW-1:0] r_mem [fifo_depth];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic          r_full;
  logic          r_empty;
  state_t        r_state;
  logic [VW-1:0] r_shift;
  logic [LW-1:0] r_lane;
  logic [7:0]    r_row_cnt;

  logic          w_push;
  logic          w_pop;
  logic          w_last_beat;
  logic [PW-1:0] w_wptr_nxt;
  logic [PW-1:0] w_rptr_nxt;
  logic [VW-1:0] w_head;

  // in_ready is gated by reset so nothing is accepted while the block is held.
  // A push is refused while full even if a pop happens in the same cycle.
  assign in_ready    = ~reset & ~r_full;
  assign w_push      = in_valid & in_ready;
  assign w_last_beat = (r_state == SHIFT) & out_ready & (r_lane == LAST_LANE);
  assign w_pop       = ~r_empty & ((r_state == IDLE) | w_last_beat);
  assign w_wptr_nxt  = r_wptr + PW'(w_push);
  assign w_rptr_nxt  = r_rptr + PW'(w_pop);
  assign w_head      = r_mem[r_rptr[AW-1:0]];

  // Vector storage; contents need no reset because the pointers gate all reads.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= in_data;
    end
  end

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  // The status flags are computed from the next pointer values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_full  <= (w_wptr_nxt[PW-1] != w_rptr_nxt[PW-1]) &&
                 (w_wptr_nxt[AW-1:0] == w_rptr_nxt[AW-1:0]);
      r_empty <= (w_wptr_nxt == w_rptr_nxt);
    end
  end

  // Serializer FSM. The shift register moves right one lane per accepted beat,
  // so the current lane always sits in the low bits. On the final lane the next
  // head is loaded directly when available, giving back-to-back vectors with
  // no bubble. The register is cleared on returning to IDLE so no stale lane
  // lingers on out_data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_lane    <= '0;
      r_row_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!r_empty) begin
            r_shift <= w_head;
            r_lane  <= '0;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (out_ready) begin
            if (r_lane == LAST_LANE) begin
              r_row_cnt <= r_row_cnt + 8'd1;
              if (!r_empty) begin
                r_shift <= w_head;
                r_lane  <= '0;
              end else begin
                r_shift <= '0;
                r_lane  <= '0;
                r_state <= IDLE;
              end
            end else begin
              r_shift <= r_shift >> bw_psum;
              r_lane  <= r_lane + LW'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign out_valid  = (r_state == SHIFT);
  assign out_data   = r_shift[bw_psum-1:0];
  assign out_lane   = r_lane;
  assign out_last   = (r_state == SHIFT) && (r_lane == LAST_LANE);
  assign row_cnt    = r_row_cnt;
  assign fifo_empty = r_empty;
  assign fifo_full  = r_full;

endmodule

// File: tb/tb_sfp_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_sfp_out_serializer
//
// Scoreboard bench for sfp_out_serializer. Every accepted vector pushes its
// col expected beats {lane, last, data} onto a queue. Each cycle with
// out_valid, the head of the queue is compared against the DUT beat. The head
// is popped only when the beat is actually taken, so a stall that changes the
// beat is caught.
// ---------------------------------------------------------------------------
module tb_sfp_out_serializer;

  localparam int COL = 8;
  localparam int BW  = 19;
  localparam int VW  = COL * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [BW-1:0] out_data;
  logic [2:0]    out_lane;
  logic          out_last;
  logic [7:0]    row_cnt;
  logic          fifo_empty;
  logic          fifo_full;

  int            vectorCount = 0;
  int            missCount   = 0;
  logic [31:0]   expQ[$];
  logic [7:0]    expRows = 8'd0;

  sfp_out_serializer #(.col(COL), .bw_psum(BW), .fifo_depth(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .row_cnt    (row_cnt),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports miscompares.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectorCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard monitor, sampled on the falling edge, midway between the
  // cycles. Inputs seen accepted here are taken at the next rising edge.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (reset) begin
      expQ.delete();
      expRows = 8'd0;
    end else begin
      if (in_valid && in_ready) begin
        for (int i = 0; i < COL; i++) begin
          expQ.push_back({9'd0, 3'(i), (i == COL - 1), in_data[i*BW +: BW]});
        end
      end
      if (out_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious", {31'd0, out_valid}, 32'd0);
        end else begin
          exp = expQ[0];
          checkOutput("beat", {9'd0, out_lane, out_last, out_data}, exp);
          if (out_ready) begin
            void'(expQ.pop_front());
            if (exp[BW]) expRows = expRows + 8'd1;
          end
        end
      end
    end
  end

  // Offer one vector and hold it until the DUT accepts it.
  task automatic applyStimulus(input logic [VW-1:0] v);
    int  tries = 0;
    bit  done  = 0;
    in_valid = 1'b1;
    in_data  = v;
    while (!done) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
      tries++;
      if (!done && tries > 500) begin
        checkOutput("pushTimeout", {31'd0, in_ready}, 32'd1);
        done = 1;
      end
    end
    in_valid = 1'b0;
  endtask

  function automatic logic [VW-1:0] randVector();
    logic [VW-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = BW'($urandom);
    return v;
  endfunction

  // Wait, within a bounded number of cycles, until every expected beat is out.
  task automatic waitDrain();
    int n = 0;
    while ((expQ.size() != 0 || out_valid) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("drain", expQ.size(), 32'd0);
    checkOutput("rows", {24'd0, row_cnt}, {24'd0, expRows});
  endtask

  initial begin
    logic [VW-1:0] v;
    logic [VW-1:0] capVecs [6];
    int            accepted;
    bit            acc;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state, sampled while reset is still high.
    #12;
    checkOutput("rstInReady", {31'd0, in_ready}, 32'd0);
    checkOutput("rstValid", {31'd0, out_valid}, 32'd0);
    checkOutput("rstEmpty", {31'd0, fifo_empty}, 32'd1);
    checkOutput("rstFull", {31'd0, fifo_full}, 32'd0);
    checkOutput("rstRow", {24'd0, row_cnt}, 32'd0);
    checkOutput("rstData", {13'd0, out_data}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("idleReady", {31'd0, in_ready}, 32'd1);

    // T1: single known vector, lane 7 negative, with a latency check.
    out_ready = 1'b1;
    for (int i = 0; i < COL - 1; i++) v[i*BW +: BW] = BW'(i + 1);
    v[7*BW +: BW] = 19'h7FFFB;
    applyStimulus(v);
    checkOutput("latEdgeN", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    checkOutput("latEdgeN1", {31'd0, out_valid}, 32'd1);
    waitDrain();
    checkOutput("t1Row", {24'd0, row_cnt}, 32'd1);
    @(posedge clk); #1;
    checkOutput("t1Idle", {31'd0, out_valid}, 32'd0);

    // T2: random backpressure while three vectors are pushed.
    fork
      begin
        for (int k = 0; k < 3; k++) applyStimulus(randVector());
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    waitDrain();

    // T3: capacity with the consumer stalled and in_valid held high.
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) capVecs[k] = randVector();
    accepted = 0;
    in_valid = 1'b1;
    in_data  = capVecs[0];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc && accepted < 5) accepted++;
      in_data = capVecs[accepted];
    end
    checkOutput("capCount", accepted, 32'd5);
    checkOutput("capFull", {31'd0, fifo_full}, 32'd1);
    checkOutput("capReady", {31'd0, in_ready}, 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waitDrain();

    // T4: three vectors queued, then drained with no gap cycles.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(randVector());
    out_ready = 1'b1;
    for (int b = 0; b < 24; b++) begin
      @(negedge clk);
      checkOutput("b2bValid", {31'd0, out_valid}, 32'd1);
    end
    waitDrain();

    // T5: reset in the middle of a vector with two more queued.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) applyStimulus(randVector());
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5Lane", {29'd0, out_lane}, 32'd3);
    reset = 1'b1;
    #1;
    checkOutput("t5Valid", {31'd0, out_valid}, 32'd0);
    checkOutput("t5Data", {13'd0, out_data}, 32'd0);
    checkOutput("t5Lane0", {29'd0, out_lane}, 32'd0);
    checkOutput("t5Row", {24'd0, row_cnt}, 32'd0);
    checkOutput("t5Empty", {31'd0, fifo_empty}, 32'd1);
    checkOutput("t5InReady", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("t5Quiet", {31'd0, out_valid}, 32'd0);

    // T6: 256 vectors to wrap row_cnt and the FIFO pointers.
    for (int k = 0; k < 256; k++) applyStimulus(randVector());
    waitDrain();
    checkOutput("rowWrap", {24'd0, row_cnt}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
